dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's ME-stage load/store requests.
- Holds a word-addressed RAM plus one memory-mapped output register that drives the seven-segment / LED display.
- Adds a programmable number of wait states and asserts busy so the pipeline controller can stall ME and everything upstream.
- Reports misaligned and unmapped accesses on err.

Parameters:
DEPTH, 1024, number of 32-bit RAM words (power of two)
BASE_ADDR, 32'h10010000, byte address of RAM word 0
MMIO_ADDR, 32'h1001FFF0, byte address of the display register (must lie outside the RAM range)
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  1  access request from ME stage; held high while stalled
we  in  1  1 = store, 0 = load; valid with req
addr  in  32  byte address; valid with req
wdata  in  32  store data; valid with req
rdata  out  32  load data; valid while ready=1, held afterwards until the next response
ready  out  1  one-cycle response strobe
busy  out  1  stall request to the pipeline controller
err  out  1  access fault; valid while ready=1
mmio_out  out  32  display register contents

Behaviour:
- Reset, asynchronous: state=IDLE, rdata=0, ready=0, err=0, mmio_out=0, wait counter=0, latched request cleared. RAM contents are not cleared.
- Reset mid-transaction: the transaction is dropped and no write occurs. A store whose RESP edge has already happened stays committed.
- States are IDLE, WAIT and RESP.
- IDLE:
  - Ignores req=0.
  - On req=1 at a rising edge: latches addr, we and wdata.
  - If WAIT_CYCLES=0, goes to RESP; otherwise loads counter=WAIT_CYCLES and goes to WAIT.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter=1, goes to RESP.
  - req, addr, we and wdata are ignored; the latched copies are used.
- Entry into RESP (the same edge):
  - Decodes the latched address.
  - Performs the store, or samples the read data into rdata.
  - Sets err.
- RESP: ready=1 for exactly this cycle, then always returns to IDLE. req seen during RESP is the completing request and is ignored. The pipeline advances ME during RESP, so a request present in the following IDLE cycle is a new request.
- busy is combinational: busy = (state==IDLE && req) || state==WAIT. It is 0 in RESP.
- Latency: request accepted at edge N; ready is high in the cycle after edge N+WAIT_CYCLES.
- Total stall cycles per access = WAIT_CYCLES+1.
- Address decode, applied to the latched addr:
  - addr[1:0]!=0: err=1, no write, rdata=0.
  - BASE_ADDR <= addr < BASE_ADDR+4*DEPTH: RAM index = (addr-BASE_ADDR)>>2, computed with 32-bit subtraction. Store writes the full word; load returns the word.
  - addr==MMIO_ADDR: store updates mmio_out; load returns mmio_out.
  - Otherwise: err=1, no write, rdata=0.
- err=0 for all valid accesses. err is cleared to 0 when leaving RESP.
- Read-after-write: a load following a store to the same address returns the new data. A store commits at its RESP-entry edge, which is always before any later request is accepted.
- Range boundaries:
  - BASE_ADDR+4*DEPTH-4 is the last valid word.
  - BASE_ADDR+4*DEPTH faults.
  - BASE_ADDR-4 faults; the subtraction wraps and must not alias into RAM.
- mmio_out changes only on a successful MMIO store.

Test Plan:
- Reset: assert rst with req=0 -> rdata=0, ready=0, busy=0, err=0, mmio_out=0, state IDLE.
- Store then load, WAIT_CYCLES=2:
  - Store addr=32'h10010008, wdata=32'hDEADBEEF -> busy high for 3 cycles, ready pulses once, err=0.
  - Then load from the same address -> rdata=32'hDEADBEEF in the ready cycle.
- WAIT_CYCLES=0: back-to-back loads at 32'h10010000 and 32'h10010004 -> each stalls 1 cycle, ready alternates with IDLE, and rdata matches previously stored values.
- MMIO: store 32'h00001234 to 32'h1001FFF0 -> mmio_out=32'h00001234 after the RESP edge; load returns 32'h00001234.
- Faults:
  - Load at 32'h10010002 -> err=1, rdata=0.
  - Store at 32'h10011000 (DEPTH=1024) -> err=1, no RAM word changes.
  - Load at 32'h1000FFFC -> err=1.
- Reset during WAIT of a store to 32'h10010010 -> FSM returns to IDLE, ready never pulses, and a later load of that address returns its old value.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ME-stage data-memory bus: request side driven by the CPU, response side by the responder.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;
    logic [31:0] mmio_out;

    modport master (output req, we, addr, wdata,
                    input  rdata, ready, busy, err, mmio_out);
    modport slave  (input  req, we, addr, wdata,
                    output rdata, ready, busy, err, mmio_out);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus one display register, with programmable
// wait states, a stall output for the pipeline and fault reporting.
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter logic [31:0] MMIO_ADDR   = 32'h1001_FFF0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mmio_q, mmio_d;
    logic        err_q, err_d;

    logic             acc_we;
    logic [31:0]      acc_addr, acc_wdata, acc_off;
    logic [IDX_W-1:0] acc_idx;
    logic             misaligned, ram_hit, mmio_hit, resp_entry, ram_wr;

    // In IDLE the access being resolved is the live request (only reaches RESP
    // directly when there are no wait states); afterwards it is the latched copy.
    always_comb begin
        acc_we     = (state_q == IDLE) ? bus.we    : we_q;
        acc_addr   = (state_q == IDLE) ? bus.addr  : addr_q;
        acc_wdata  = (state_q == IDLE) ? bus.wdata : wdata_q;
        acc_off    = acc_addr - BASE_ADDR;
        acc_idx    = acc_off[IDX_W+1:2];
        misaligned = acc_addr[1:0] != 2'b00;
        // Wrapped offsets (addresses below BASE_ADDR) are huge and fall out of range.
        ram_hit    = !misaligned && (acc_off < RAM_BYTES);
        mmio_hit   = !misaligned && (acc_addr == MMIO_ADDR);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mmio_d     = mmio_q;
        err_d      = err_q;
        resp_entry = 1'b0;
        case (state_q)
            IDLE: if (bus.req) begin
                we_d    = bus.we;
                addr_d  = bus.addr;
                wdata_d = bus.wdata;
                if (WAIT_CYCLES == 0) begin
                    state_d    = RESP;
                    resp_entry = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    resp_entry = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (resp_entry) begin
            err_d = !(ram_hit || mmio_hit);
            if (!(ram_hit || mmio_hit))
                rdata_d = 32'h0;
            else if (!acc_we)
                rdata_d = ram_hit ? mem[acc_idx] : mmio_q;
            if (acc_we && mmio_hit)
                mmio_d = acc_wdata;
        end
    end

    assign ram_wr = resp_entry && acc_we && ram_hit && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mmio_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mmio_q  <= mmio_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) mem[acc_idx] <= acc_wdata;
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = (state_q == RESP);
    assign bus.busy     = ((state_q == IDLE) && bus.req) || (state_q == WAIT);
    assign bus.err      = err_q;
    assign bus.mmio_out = mmio_q;
endmodule
